// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the RAM BIST engine.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (1024 x 8)
//   state_t                 : BIST controller state encoding
package ram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_bist_patgen.sv
// ram_bist_patgen -- test pattern word for one address.
//   addr_lsb : low DATA_W bits of the RAM address
//   seed     : run seed
//   pass     : 0 = true pattern, 1 = complemented pattern
//   word     : pattern word
module ram_bist_patgen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] addr_lsb,
  input  logic [DATA_W-1:0] seed,
  input  logic              pass,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] base;

  assign base = addr_lsb ^ seed;
  assign word = pass ? ~base : base;

endmodule

// File: rtl/ram_bist.sv
// ram_bist -- two-pass write/read-back self test for a synchronous RAM.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, seed           : launch request (IDLE/DONE only) and pattern seed
//   addr, din, w_en, dout : RAM interface (dout valid one cycle after addr)
//   busy, done            : run in progress / run complete (sticky)
//   fail, fail_addr/data  : sticky failure flag, first failing address and read value
//   err_cnt               : saturating mismatch count, present only when
//                           RAM_BIST_ERRCNT_EN is defined
module ram_bist
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              w_en,
  input  logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [ADDR_W:0]   err_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_reg, state_next;
  logic              pass_reg, pass_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] seed_reg, seed_next;
  logic              cmp_valid_reg;
  logic [ADDR_W-1:0] cmp_addr_reg;
  logic              start_ok;
  logic              mismatch;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] exp_word;

  assign start_ok = start && (state_reg == ST_IDLE || state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    pass_next  = pass_reg;
    addr_next  = addr_reg;
    seed_next  = seed_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_WRITE;
          pass_next  = 1'b0;
          addr_next  = '0;
          seed_next  = seed;
        end
      end
      ST_WRITE: begin
        if (addr_reg == ADDR_MAX) begin
          state_next = ST_READ;
          addr_next  = '0;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      ST_READ: begin
        addr_next = addr_reg + 1'b1;
        if (addr_reg == ADDR_MAX) begin
          state_next = ST_DRAIN;
          addr_next  = '0;
        end
      end
      ST_DRAIN: begin
        addr_next = '0;
        if (!pass_reg) begin
          state_next = ST_WRITE;
          pass_next  = 1'b1;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write data is generated for the *next* address so din/w_en can be
  // registered and still line up with addr.
  ram_bist_patgen #(.DATA_W(DATA_W)) u_patgen_wr (
    .addr_lsb (addr_next[DATA_W-1:0]),
    .seed     (seed_next),
    .pass     (pass_next),
    .word     (wr_word)
  );

  // Expected data for the address read one cycle earlier.
  ram_bist_patgen #(.DATA_W(DATA_W)) u_patgen_exp (
    .addr_lsb (cmp_addr_reg[DATA_W-1:0]),
    .seed     (seed_reg),
    .pass     (pass_reg),
    .word     (exp_word)
  );

  assign mismatch = cmp_valid_reg && (dout != exp_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pass_reg      <= 1'b0;
      addr_reg      <= '0;
      seed_reg      <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_addr_reg  <= '0;
      din           <= '0;
      w_en          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
    end else begin
      state_reg     <= state_next;
      pass_reg      <= pass_next;
      addr_reg      <= addr_next;
      seed_reg      <= seed_next;
      cmp_valid_reg <= (state_reg == ST_READ);
      cmp_addr_reg  <= addr_reg;
      w_en          <= (state_next == ST_WRITE);
      din           <= (state_next == ST_WRITE) ? wr_word : '0;
      busy          <= (state_next == ST_WRITE) || (state_next == ST_READ) ||
                       (state_next == ST_DRAIN);
      if (start_ok) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else begin
        if (state_reg == ST_DRAIN && pass_reg) done <= 1'b1;
        // Only the first mismatch of a run is recorded.
        if (mismatch && !fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr_reg;
          fail_data <= dout;
        end
      end
    end
  end

  assign addr = addr_reg;

`ifdef RAM_BIST_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (start_ok) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != {(ADDR_W+1){1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist -- self-checking bench for ram_bist with a 1024x8 sync RAM
// model that can hold bit 3 of address 788 at 0. Run outcomes are queued as
// expectations at launch and compared when the run finishes.
// Build with RAM_BIST_ERRCNT_EN defined to also check err_cnt.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [9:0] addr;
  logic [7:0] din;
  logic       w_en;
  logic [7:0] dout;
  logic       busy, done, fail;
  logic [9:0] fail_addr;
  logic [7:0] fail_data;
`ifdef RAM_BIST_ERRCNT_EN
  logic [10:0] err_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] cur_seed = 8'h00;
  int         wr_cnt   = 0;
  bit         fault_en = 1'b0;
  logic [7:0] mem [1024];

  typedef struct {
    int         cycles;
    logic       fail;
    logic [9:0] fail_addr;
    logic [7:0] fail_data;
    int         errs;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ram_bist dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .addr      (addr),
    .din       (din),
    .w_en      (w_en),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
`ifdef RAM_BIST_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // Synchronous RAM with an optional stuck-at-0 cell.
  always @(posedge clk) begin
    if (w_en) mem[addr] <= (fault_en && addr == 10'd788) ? (din & 8'hF7) : din;
    dout <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [9:0] a, input logic [7:0] s, input bit p);
    logic [7:0] w;
    w = a[7:0] ^ s;
    return p ? ~w : w;
  endfunction

  // Write-stream monitor: din must follow the pattern during WRITE, 0 otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) begin
        check("din", {24'd0, din}, {24'd0, pat(addr, cur_seed, wr_cnt >= 1024)});
        if (addr == 10'd1010 && cur_seed == 8'hA5 && wr_cnt < 1024)
          check("din_1010", {24'd0, din}, 32'h57);
        wr_cnt++;
      end else begin
        check("din_idle", {24'd0, din}, 32'd0);
        if (!busy) wr_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {22'd0, addr}, 32'd0);
    check({tag, "_outs"}, {27'd0, din == 8'd0, w_en, busy, done, fail}, 32'h10);
    check({tag, "_faddr"}, {22'd0, fail_addr}, 32'd0);
    check({tag, "_fdata"}, {24'd0, fail_data}, 32'd0);
`ifdef RAM_BIST_ERRCNT_EN
    check({tag, "_errcnt"}, {21'd0, err_cnt}, 32'd0);
`endif
  endtask

  task automatic launch(input logic [7:0] s);
    @(negedge clk);
    seed = s; cur_seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until the run ends; optionally pulses start mid-run.
  task automatic wait_done(input int inject_at, output int cnt);
    bit ended;
    cnt = 0; ended = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!busy) begin ended = 1'b1; break; end
      cnt++;
      if (cnt == inject_at) begin start = 1'b1; seed = 8'hFF; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (!ended) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(input bit f, input logic [9:0] fa, input logic [7:0] fd, input int errs);
    exp_t e;
    e.cycles = 4098; e.fail = f; e.fail_addr = fa; e.fail_data = fd; e.errs = errs;
    exp_q.push_back(e);
  endtask

  task automatic score(input string tag, input int cnt);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_cycles"}, cnt, e.cycles);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_fail"}, {31'd0, fail}, {31'd0, e.fail});
    check({tag, "_faddr"}, {22'd0, fail_addr}, {22'd0, e.fail_addr});
    check({tag, "_fdata"}, {24'd0, fail_data}, {24'd0, e.fail_data});
`ifdef RAM_BIST_ERRCNT_EN
    check({tag, "_errcnt"}, {21'd0, err_cnt}, e.errs);
`endif
    $display("run %s: %0d busy cycles, fail=%0b fail_addr=%0d fail_data=0x%0h",
             tag, cnt, fail, fail_addr, fail_data);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Fault-free run, seed 0x00.
    push_exp(1'b0, 10'd0, 8'd0, 0);
    launch(8'h00);
    wait_done(-1, cnt);
    score("seed00", cnt);

    // Seed 0xA5: write-stream monitor spot-checks addr 1010.
    push_exp(1'b0, 10'd0, 8'd0, 0);
    launch(8'hA5);
    wait_done(-1, cnt);
    score("seedA5", cnt);

    // Stuck-at-0 on bit 3 of address 788: pass 0 reads 0x14 instead of 0x1C.
    fault_en = 1'b1;
    push_exp(1'b1, 10'd788, 8'h14, 1);
    launch(8'h08);
    wait_done(-1, cnt);
    score("stuck", cnt);
    fault_en = 1'b0;

    // Reset at busy cycle 500 clears everything at once.
    launch(8'h3C);
    repeat (499) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    push_exp(1'b0, 10'd0, 8'd0, 0);
    launch(8'h3C);
    check("restart_addr", {22'd0, addr}, 32'd0);
    check("restart_wen", {31'd0, w_en}, 32'd1);
    wait_done(-1, cnt);
    score("after_rst", cnt);

    // start while busy is ignored; start in DONE relaunches and clears done.
    push_exp(1'b0, 10'd0, 8'd0, 0);
    launch(8'h5A);
    wait_done(100, cnt);
    score("busy_start", cnt);
    push_exp(1'b0, 10'd0, 8'd0, 0);
    launch(8'hC3);
    check("relaunch_done", {31'd0, done}, 32'd0);
    check("relaunch_busy", {31'd0, busy}, 32'd1);
    wait_done(-1, cnt);
    score("relaunch", cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
